// File: rtl/alu_exec_stage_if.sv
// Bundle of the execute stage's upstream, ALU-side and downstream signals.
// The slave modport is the stage; the master modport is its environment.
interface alu_exec_stage_if #(
  parameter int DW   = 32,
  parameter int OPW  = 3,
  parameter int TAGW = 5,
  parameter int CNTW = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_a;
  logic [DW-1:0]   in_b;
  logic            in_diff;
  logic [OPW-1:0]  in_op;
  logic [TAGW-1:0] in_tag;

  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic            alu_diff;
  logic [OPW-1:0]  alu_op;
  logic [DW-1:0]   alu_res;
  logic            alu_cy;

  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_res;
  logic            out_cy;
  logic            out_zero;
  logic            out_neg;
  logic [TAGW-1:0] out_tag;
  logic [CNTW-1:0] retired;

  modport slave (
    input  in_valid, in_a, in_b, in_diff, in_op, in_tag, alu_res, alu_cy, out_ready,
    output in_ready, alu_a, alu_b, alu_diff, alu_op,
    output out_valid, out_res, out_cy, out_zero, out_neg, out_tag, retired
  );

  modport master (
    output in_valid, in_a, in_b, in_diff, in_op, in_tag, alu_res, alu_cy, out_ready,
    input  in_ready, alu_a, alu_b, alu_diff, alu_op,
    input  out_valid, out_res, out_cy, out_zero, out_neg, out_tag, retired
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Two-register execute stage around an external combinational ALU:
// S1 holds operands feeding the ALU, S2 captures result plus derived flags.
module alu_exec_stage #(
  parameter int DW   = 32,
  parameter int OPW  = 3,
  parameter int TAGW = 5,
  parameter int CNTW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  alu_exec_stage_if.slave bus
);

  logic            s1_valid;
  logic [TAGW-1:0] s1_tag;
  logic            adv;
  logic            accept;
  logic            hs;

  assign adv         = s1_valid & (~bus.out_valid | bus.out_ready);
  // in_ready looks through to out_ready so a full pipe still streams 1 op/cycle
  assign bus.in_ready = ~flush & (~s1_valid | adv);
  assign accept      = bus.in_valid & bus.in_ready;
  assign hs          = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_tag        <= '0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_diff  <= 1'b0;
      bus.alu_op    <= '0;
      bus.out_valid <= 1'b0;
      bus.out_res   <= '0;
      bus.out_cy    <= 1'b0;
      bus.out_zero  <= 1'b0;
      bus.out_neg   <= 1'b0;
      bus.out_tag   <= '0;
      bus.retired   <= '0;
    end else begin
      if (accept) begin
        bus.alu_a    <= bus.in_a;
        bus.alu_b    <= bus.in_b;
        bus.alu_diff <= bus.in_diff;
        bus.alu_op   <= bus.in_op;
        s1_tag       <= bus.in_tag;
      end
      if (adv) begin
        bus.out_res  <= bus.alu_res;
        bus.out_cy   <= bus.alu_cy;
        bus.out_zero <= (bus.alu_res == '0);
        bus.out_neg  <= bus.alu_res[DW-1];
        bus.out_tag  <= s1_tag;
      end
      // a handshake coinciding with flush still retires
      if (hs) bus.retired <= bus.retired + CNTW'(1);
      if (flush) begin
        s1_valid      <= 1'b0;
        bus.out_valid <= 1'b0;
      end else begin
        s1_valid      <= accept ? 1'b1 : (adv ? 1'b0 : s1_valid);
        bus.out_valid <= adv ? 1'b1 : (hs ? 1'b0 : bus.out_valid);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized bench for alu_exec_stage: an ALU model closes the loop and an
// in-order queue of expected results tracks every accepted op.
module tb_alu_exec_stage;
  typedef struct packed {
    logic [31:0] res;
    logic        cy;
    logic        zero;
    logic        neg;
    logic [4:0]  tag;
  } rsp_t;

  logic clk, rst, flush;
  alu_exec_stage_if bus ();

  alu_exec_stage dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  rsp_t exp_q[$];
  logic acc, ret, have;
  rsp_t got, exp;
  logic [31:0] ra, rb;
  logic rd;
  logic [2:0] rop;
  logic [4:0] rt;

  // External ALU: op0 add/sub with carry-out, a few logic ops otherwise
  function automatic logic [32:0] alu_fn(logic [31:0] a, logic [31:0] b, logic d, logic [2:0] op);
    case (op)
      3'd0:    alu_fn = d ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b});
      3'd1:    alu_fn = {1'b0, a & b};
      3'd2:    alu_fn = {1'b0, a | b};
      3'd3:    alu_fn = {1'b0, a ^ b};
      default: alu_fn = {1'b0, a};
    endcase
  endfunction

  assign {bus.alu_cy, bus.alu_res} = alu_fn(bus.alu_a, bus.alu_b, bus.alu_diff, bus.alu_op);

  function automatic rsp_t model(logic [31:0] a, logic [31:0] b, logic d, logic [2:0] op, logic [4:0] tag);
    logic [32:0] r;
    r = alu_fn(a, b, d, op);
    return {r[31:0], r[32], r[31:0] == 32'd0, r[31], tag};
  endfunction

  task automatic randop();
    ra  = $urandom;
    rb  = ($urandom_range(0, 7) == 0) ? ra : $urandom;
    rd  = 1'($urandom);
    rop = 3'($urandom_range(0, 3));
    rt  = 5'($urandom);
  endtask

  // Drive one cycle's inputs at negedge, sample what the next posedge will do,
  // and keep the expected-result queue in step.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b, input logic d,
                       input logic [2:0] op, input logic [4:0] tag, input logic ordy, input logic fl);
    @(negedge clk);
    bus.in_valid = v; bus.in_a = a; bus.in_b = b; bus.in_diff = d;
    bus.in_op = op; bus.in_tag = tag; bus.out_ready = ordy; flush = fl;
    #1;
    acc  = v & bus.in_ready;
    ret  = bus.out_valid & ordy;
    got  = {bus.out_res, bus.out_cy, bus.out_zero, bus.out_neg, bus.out_tag};
    have = 1'b0;
    exp  = '0;
    if (ret && exp_q.size() != 0) begin
      have = 1'b1;
      exp  = exp_q.pop_front();
    end
    if (fl) exp_q.delete();
    if (acc) exp_q.push_back(model(a, b, d, op, tag));
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.retired !== 16'd0) begin errors++; $display("FAIL reset_retired got=%0d exp=0", bus.retired); end
    checks++; if (bus.out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero got=%b exp=0", bus.out_zero); end
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_basic();
    cycle(1'b1, 32'd5, 32'd3, 1'b0, 3'd0, 5'd7, 1'b1, 1'b0);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL basic_accept got=%b exp=1", acc); end
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b1, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", bus.out_valid); end
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b1, 1'b0);
    checks++;
    if (ret !== 1'b1 || got !== {32'd8, 1'b0, 1'b0, 1'b0, 5'd7}) begin
      errors++; $display("FAIL basic_result valid=%b got=%h exp=%h", ret, got, {32'd8, 1'b0, 1'b0, 1'b0, 5'd7});
    end
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b1, 1'b0);
    checks++; if (bus.retired !== 16'd1) begin errors++; $display("FAIL basic_retired got=%0d exp=1", bus.retired); end
  endtask

  task automatic test_flags();
    logic [31:0] fa[3];
    logic [31:0] fb[3];
    logic        fd[3];
    logic        ok;
    fa = '{32'd5, 32'h8000_0000, 32'hFFFF_FFFF};
    fb = '{32'd5, 32'd0, 32'd1};
    fd = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, fa[i], fb[i], fd[i], 3'd0, 5'(i + 1), 1'b1, 1'b0);
      ret = 1'b0;
      for (int k = 0; k < 4 && !ret; k++) cycle(1'b0, 32'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b1, 1'b0);
      case (i)
        0:       ok = got.zero && got.res == 32'd0 && !got.neg;
        1:       ok = got.neg && !got.zero && got.res == 32'h8000_0000;
        default: ok = got.res == 32'd0 && got.cy && got.zero && !got.neg;
      endcase
      checks++;
      if (!ret || !have || got !== exp || !ok) begin
        errors++; $display("FAIL flags_case%0d valid=%b got=%h exp=%h", i, ret, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_ret = 0, first = -1, last = -1, miss = 0, bad = 0;
    for (int i = 0; i < 14; i++) begin
      randop();
      cycle(1'(i < 10), ra, rb, rd, rop, rt, 1'b1, 1'b0);
      if (i < 10 && !acc) miss++;
      if (ret) begin
        if (first < 0) first = i;
        last = i;
        n_ret++;
        if (!have || got !== exp) begin
          bad++; $display("FAIL b2b_result idx=%0d got=%h exp=%h", n_ret - 1, got, exp);
        end
      end
    end
    checks++; if (miss != 0) begin errors++; $display("FAIL b2b_in_ready stalls=%0d exp=0", miss); end
    checks++; if (n_ret != 10) begin errors++; $display("FAIL b2b_count got=%0d exp=10", n_ret); end
    checks++; if (last - first != 9) begin errors++; $display("FAIL b2b_spacing span=%0d exp=9", last - first); end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_data bad=%0d exp=0", bad); end
    checks++; if (bus.retired !== 16'd14) begin errors++; $display("FAIL b2b_retired got=%0d exp=14", bus.retired); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a[3], b[3];
    logic        d[3];
    logic [2:0]  op[3];
    logic [4:0]  tg[3];
    int idx = 0, n_ret = 0, bad = 0;
    rsp_t snap;
    for (int i = 0; i < 3; i++) begin
      randop(); a[i] = ra; b[i] = rb; d[i] = rd; op[i] = rop; tg[i] = rt;
    end
    snap = '0;
    for (int c = 0; c < 4; c++) begin
      cycle(1'b1, a[idx], b[idx], d[idx], op[idx], tg[idx], 1'b0, 1'b0);
      if (acc) idx++;
      if (c == 2) snap = got;
    end
    checks++; if (idx != 2) begin errors++; $display("FAIL bp_held got=%0d exp=2", idx); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b1 || got !== snap) begin
      errors++; $display("FAIL bp_stable valid=%b got=%h exp=%h", bus.out_valid, got, snap);
    end
    for (int c = 0; c < 10; c++) begin
      cycle(1'(idx < 3), a[idx % 3], b[idx % 3], d[idx % 3], op[idx % 3], tg[idx % 3], 1'b1, 1'b0);
      if (acc) idx++;
      if (ret) begin
        n_ret++;
        if (!have || got !== exp) bad++;
      end
    end
    checks++; if (idx != 3) begin errors++; $display("FAIL bp_accepted got=%0d exp=3", idx); end
    checks++; if (n_ret != 3) begin errors++; $display("FAIL bp_count got=%0d exp=3", n_ret); end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_order bad=%0d exp=0", bad); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      randop();
      cycle(1'b1, ra, rb, rd, rop, rt, 1'b0, 1'b0);
    end
    randop();
    cycle(1'b1, ra, rb, rd, rop, rt, 1'b0, 1'b1);
    checks++; if (acc !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b exp=0", acc); end
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_empty out_valid=%b in_ready=%b exp=0/1", bus.out_valid, bus.in_ready);
    end
    checks++; if (bus.retired !== 16'd17) begin errors++; $display("FAIL flush_retired got=%0d exp=17", bus.retired); end
    randop();
    cycle(1'b1, ra, rb, rd, rop, rt, 1'b1, 1'b0);
    ret = 1'b0;
    for (int k = 0; k < 4 && !ret; k++) cycle(1'b0, 32'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b1, 1'b0);
    checks++;
    if (!ret || !have || got !== exp) begin
      errors++; $display("FAIL flush_next_op valid=%b got=%h exp=%h", ret, got, exp);
    end
    randop();
    cycle(1'b1, ra, rb, rd, rop, rt, 1'b0, 1'b0);
    checks++; if (bus.retired !== 16'd18) begin errors++; $display("FAIL flush_retired2 got=%0d exp=18", bus.retired); end
    for (int k = 0; k < 4 && !bus.out_valid; k++) cycle(1'b0, 32'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b1, 1'b1);
    checks++;
    if (!ret || !have || got !== exp) begin
      errors++; $display("FAIL flush_hs_data valid=%b got=%h exp=%h", ret, got, exp);
    end
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (bus.retired !== 16'd19 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_hs_count retired=%0d out_valid=%b exp=19/0", bus.retired, bus.out_valid);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      randop();
      cycle(1'b1, ra, rb, rd, rop, rt, 1'b1, 1'b0);
    end
    #6;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got=%b exp=1", bus.out_valid); end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.retired !== 16'd0) begin
      errors++; $display("FAIL arst_clear out_valid=%b retired=%0d exp=0/0", bus.out_valid, bus.retired);
    end
    exp_q.delete();
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    randop();
    cycle(1'b1, ra, rb, rd, rop, rt, 1'b1, 1'b0);
    ret = 1'b0;
    for (int k = 0; k < 4 && !ret; k++) cycle(1'b0, 32'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b1, 1'b0);
    checks++;
    if (!ret || !have || got !== exp) begin
      errors++; $display("FAIL arst_resume valid=%b got=%h exp=%h", ret, got, exp);
    end
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b1, 1'b0);
    checks++; if (bus.retired !== 16'd1) begin errors++; $display("FAIL arst_retired got=%0d exp=1", bus.retired); end
  endtask

  task automatic test_wrap();
    int n = 0, bad = 0;
    do begin
      randop();
      cycle(1'b1, ra, rb, rd, rop, rt, 1'b1, 1'b0);
      if (ret && (!have || got !== exp)) bad++;
      n++;
    end while (({1'b0, bus.retired} + {16'd0, ret}) != 17'h0FFFF && n < 70000);
    checks++; if (n >= 70000) begin errors++; $display("FAIL wrap_timeout cycles=%0d retired=%0d", n, bus.retired); end
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_stream bad=%0d exp=0", bad); end
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (bus.retired !== 16'hFFFF || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_preset retired=%h out_valid=%b exp=ffff/1", bus.retired, bus.out_valid);
    end
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b1);
    checks++; if (bus.retired !== 16'd0) begin errors++; $display("FAIL wrap_zero got=%h exp=0", bus.retired); end
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_diff = 1'b0;
    bus.in_op = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_flags();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
